// File: rtl/gradient_stepper.sv
// Gradient step generator: frame-divided phase animation (wrap or bounce)
// plus a per-line spatial sweep derived from the active-column counter.
module gradient_stepper #(
    parameter int FRAME_DIV = 4,
    parameter int COL_SHIFT = 5,
    parameter int COL_W     = 12
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       vsync,
    input  logic       de,
    input  logic       en,
    input  logic       pingpong,
    output logic [3:0] step,
    output logic [3:0] phase,
    output logic       frame_tick
);

    typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

    localparam logic [7:0]       FRAME_LAST = 8'(FRAME_DIV - 1);
    localparam logic [COL_W-1:0] COL_MAX    = '1;
    localparam logic [COL_W-1:0] COL_ONE    = COL_W'(1);

    logic             vsync_d_reg;
    logic             frame_tick_reg;
    logic [7:0]       frame_cnt_reg;
    logic [COL_W-1:0] col_reg;
    dir_t             dir_reg;
    logic [3:0]       phase_reg;
    logic [3:0]       step_reg;

    logic             vsync_edge;
    logic             update;
    logic [3:0]       col_bits;

    assign vsync_edge = vsync & ~vsync_d_reg;
    assign update     = vsync_edge & en & (frame_cnt_reg == FRAME_LAST);

    // Column bits that fall past the top of the counter read as zero.
    for (genvar gi = 0; gi < 4; gi++) begin : g_colbit
        if (COL_SHIFT + gi < COL_W) begin : g_in
            assign col_bits[gi] = col_reg[COL_SHIFT+gi];
        end else begin : g_out
            assign col_bits[gi] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vsync_d_reg    <= 1'b0;
            frame_tick_reg <= 1'b0;
            frame_cnt_reg  <= 8'd0;
            col_reg        <= '0;
            dir_reg        <= DIR_UP;
            phase_reg      <= 4'd0;
            step_reg       <= 4'd0;
        end else begin
            vsync_d_reg    <= vsync;
            frame_tick_reg <= vsync_edge;

            if (vsync_edge && en) begin
                frame_cnt_reg <= (frame_cnt_reg == FRAME_LAST) ? 8'd0 : frame_cnt_reg + 8'd1;
            end

            // pingpong only matters at the moment an update fires
            if (update) begin
                if (!pingpong) begin
                    phase_reg <= phase_reg + 4'd1;
                    dir_reg   <= DIR_UP;
                end else if (dir_reg == DIR_UP) begin
                    if (phase_reg == 4'd15) begin
                        phase_reg <= 4'd14;
                        dir_reg   <= DIR_DOWN;
                    end else begin
                        phase_reg <= phase_reg + 4'd1;
                    end
                end else begin
                    if (phase_reg == 4'd0) begin
                        phase_reg <= 4'd1;
                        dir_reg   <= DIR_UP;
                    end else begin
                        phase_reg <= phase_reg - 4'd1;
                    end
                end
            end

            if (!de) begin
                col_reg <= '0;
            end else if (col_reg != COL_MAX) begin
                col_reg <= col_reg + COL_ONE;
            end

            step_reg <= de ? (phase_reg + col_bits) : phase_reg;
        end
    end

    assign step       = step_reg;
    assign phase      = phase_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_gradient_stepper.sv
// Directed bench for gradient_stepper with defaults FRAME_DIV=4, COL_SHIFT=5, COL_W=12.
module tb_gradient_stepper;

    logic       clk = 1'b0;
    logic       rstn;
    logic       vsync;
    logic       de;
    logic       en;
    logic       pingpong;
    logic [3:0] step;
    logic [3:0] phase;
    logic       frame_tick;

    int errors = 0;
    int checks = 0;

    gradient_stepper #(
        .FRAME_DIV(4),
        .COL_SHIFT(5),
        .COL_W(12)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .vsync(vsync),
        .de(de),
        .en(en),
        .pingpong(pingpong),
        .step(step),
        .phase(phase),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One vsync pulse with de low; checks tick shape, phase and step=phase.
    task automatic vpulse(input string tag, input int exp_phase);
        @(negedge clk) vsync = 1'b1;
        @(negedge clk);
        check({tag, "_tick_hi"}, int'(frame_tick), 1);
        check({tag, "_phase"}, int'(phase), exp_phase);
        vsync = 1'b0;
        @(negedge clk);
        check({tag, "_tick_lo"}, int'(frame_tick), 0);
        check({tag, "_step"}, int'(step), exp_phase);
        $display("pulse %s phase=%0d step=%0d", tag, phase, step);
    endtask

    function automatic int bounce(input int k);
        if (k <= 15)      return k;
        else if (k <= 30) return 30 - k;
        else if (k <= 45) return k - 30;
        else              return 60 - k;
    endfunction

    initial begin
        rstn = 1'b0; vsync = 1'b0; de = 1'b0; en = 1'b1; pingpong = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_step", int'(step), 0);
        check("rst_phase", int'(phase), 0);
        check("rst_tick", int'(frame_tick), 0);
        rstn = 1'b1;
        @(negedge clk);

        // Wrap mode: phase advances every 4th edge
        for (int n = 1; n <= 12; n++) vpulse($sformatf("wrap%0d", n), n / 4);

        // Spatial sweep at phase 3
        @(negedge clk) de = 1'b1;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            check($sformatf("sweep_col%0d", k), int'(step), (3 + (k >> 5)) % 16);
        end
        de = 1'b0;
        @(negedge clk);
        check("sweep_after_de", int'(step), 3);
        $display("sweep done step=%0d", step);

        for (int n = 13; n <= 23; n++) vpulse($sformatf("wrap%0d", n), n / 4);

        // Edge coincident with first active pixel, phase 5 -> 6
        @(negedge clk) begin vsync = 1'b1; de = 1'b1; end
        @(negedge clk);
        check("coinc_step0", int'(step), 5);
        check("coinc_phase", int'(phase), 6);
        vsync = 1'b0;
        @(negedge clk);
        check("coinc_step1", int'(step), 6);
        $display("coincident edge step=%0d phase=%0d", step, phase);
        de = 1'b0;
        @(negedge clk);

        for (int n = 25; n <= 30; n++) vpulse($sformatf("wrap%0d", n), n / 4);

        // Disabled: ticks continue, phase/counter hold (counter at 2)
        en = 1'b0;
        for (int n = 1; n <= 10; n++) vpulse($sformatf("hold%0d", n), 7);
        en = 1'b1;
        vpulse("resume1", 7);
        vpulse("resume2", 8);

        // Reset, then bounce mode from phase 0
        @(negedge clk) rstn = 1'b0;
        @(negedge clk);
        check("rst2_phase", int'(phase), 0);
        rstn = 1'b1;
        @(negedge clk);
        for (int n = 1; n <= 204; n++) begin
            pingpong = (n % 4 == 2) ? 1'b0 : 1'b1;
            vpulse($sformatf("bounce%0d", n), bounce(n / 4));
        end
        pingpong = 1'b1;
        vpulse("pre_rst1", 9);
        vpulse("pre_rst2", 9);

        // Mid-line asynchronous reset at phase 9 DOWN, col 200
        @(negedge clk) de = 1'b1;
        repeat (200) @(negedge clk);
        check("pre_rst_step", int'(step), 15);
        #2 rstn = 1'b0;
        #1;
        check("async_step", int'(step), 0);
        check("async_phase", int'(phase), 0);
        check("async_tick", int'(frame_tick), 0);
        $display("async reset step=%0d phase=%0d", step, phase);
        @(negedge clk) rstn = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            check($sformatf("post_rst_col%0d", k), int'(step), k >> 5);
        end
        de = 1'b0;
        @(negedge clk);
        for (int n = 1; n <= 8; n++) vpulse($sformatf("post_rst%0d", n), n / 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
